// File: rtl/inst_queue.sv
// Instruction queue: 2-wide in, 2-wide out circular buffer, DEPTH entries of {inst, pc}; optional INST_QUEUE_BYPASS_EN.
// Latency 1 cycle (0 with bypass on an empty queue); in_ready drops when fewer than 2 free entries, fetch holds the bundle.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module inst_queue #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [1:0]          in_valid,
  input  logic [2*INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]     in_pc,
  output logic                in_ready,
  output logic [1:0]          out_valid,
  output logic [2*INST_W-1:0] out_inst,
  output logic [2*PC_W-1:0]   out_pc,
  input  logic [1:0]          dec_take
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [INST_W-1:0] NOP_INST = INST_W'(`NOP);

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];

  logic [AW-1:0] head, tail, head_nx, tail_nx;
  logic [CW-1:0] count;

  logic [INST_W-1:0] slot_inst [2];
  logic [PC_W-1:0]   slot_pc   [2];

  logic       enq_ok;
  logic       bypass;
  logic       wr_sel1;
  logic [1:0] n_in, avail, deq, q_deq, wr_n;

  assign head_nx = head + AW'(1);
  assign tail_nx = tail + AW'(1);

  always_comb begin
    slot_inst[0] = in_inst[INST_W-1:0];
    slot_inst[1] = in_inst[2*INST_W-1:INST_W];
    slot_pc[0]   = in_pc;
    slot_pc[1]   = in_pc + PC_W'(4);

    // Readiness comes from registered count only, so fetch never sees a path from dec_take.
    in_ready = (count <= CW'(DEPTH - 2));
    enq_ok   = in_valid[0] && in_ready && !flush;
    n_in     = enq_ok ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    avail    = (count >= CW'(2)) ? 2'd2 : count[1:0];

    bypass = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bypass = (count == '0) && !flush;
`endif
    if (bypass) begin
      avail = n_in;
    end

    deq = (dec_take > avail) ? avail : dec_take;

    // In bypass the queue is empty: decode takes from the bundle, the rest lands at tail.
    if (bypass) begin
      q_deq   = 2'd0;
      wr_n    = n_in - deq;
      wr_sel1 = deq[0];
    end else begin
      q_deq   = deq;
      wr_n    = n_in;
      wr_sel1 = 1'b0;
    end
  end

  always_comb begin
    out_valid = {count >= CW'(2), count >= CW'(1)};
    out_inst  = {NOP_INST, NOP_INST};
    out_pc    = '0;
    if (count >= CW'(1)) begin
      out_inst[INST_W-1:0] = mem_inst[head];
      out_pc[PC_W-1:0]     = mem_pc[head];
    end
    if (count >= CW'(2)) begin
      out_inst[2*INST_W-1:INST_W] = mem_inst[head_nx];
      out_pc[2*PC_W-1:PC_W]       = mem_pc[head_nx];
    end
`ifdef INST_QUEUE_BYPASS_EN
    if (bypass) begin
      out_valid = {n_in == 2'd2, n_in != 2'd0};
      out_inst  = {NOP_INST, NOP_INST};
      out_pc    = '0;
      if (n_in != 2'd0) begin
        out_inst[INST_W-1:0] = slot_inst[0];
        out_pc[PC_W-1:0]     = slot_pc[0];
      end
      if (n_in == 2'd2) begin
        out_inst[2*INST_W-1:INST_W] = slot_inst[1];
        out_pc[2*PC_W-1:PC_W]       = slot_pc[1];
      end
    end
`endif
  end

  // Entry storage is never cleared; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_n != 2'd0) begin
        mem_inst[tail] <= wr_sel1 ? slot_inst[1] : slot_inst[0];
        mem_pc[tail]   <= wr_sel1 ? slot_pc[1]   : slot_pc[0];
      end
      if (wr_n == 2'd2) begin
        mem_inst[tail_nx] <= slot_inst[1];
        mem_pc[tail_nx]   <= slot_pc[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(q_deq);
      tail  <= tail + AW'(wr_n);
      count <= count + CW'(wr_n) - CW'(q_deq);
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed vector table, wrap sequence, and randomized run against a queue model.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module tb_inst_queue;
  localparam int DEPTH = 8;
  localparam int IW    = 32;
  localparam int PW    = 32;
  localparam logic [31:0] NOPV = `NOP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_ready;
  logic [1:0]  in_valid, dec_take, out_valid;
  logic [63:0] in_inst, out_inst, out_pc;
  logic [31:0] in_pc;

  inst_queue #(.DEPTH(DEPTH), .INST_W(IW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .dec_take(dec_take)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t q[$];

  typedef struct {
    logic rst_n; logic flush; logic [1:0] v; logic [1:0] take; logic [31:0] pc;
    logic [1:0] ev; logic [31:0] p0; logic [31:0] p1; logic rdy;
  } vec_t;

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  function automatic vec_t V(input logic r, input logic f, input logic [1:0] v,
                             input logic [1:0] t, input logic [31:0] pc, input logic [1:0] ev,
                             input logic [31:0] p0, input logic [31:0] p1, input logic rdy);
    vec_t x;
    x.rst_n = r; x.flush = f; x.v = v; x.take = t; x.pc = pc;
    x.ev = ev; x.p0 = p0; x.p1 = p1; x.rdy = rdy;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; flush = 1'b0; in_valid = 2'b00; dec_take = 2'd0;
    in_pc = 32'h0; in_inst = 64'h0;
  endtask

  // Apply one vector for one edge, then idle inputs and check the registered result.
  task automatic run_vec(input vec_t t, input string tag);
    @(negedge clk);
    rst_n = t.rst_n; flush = t.flush; in_valid = t.v; dec_take = t.take;
    in_pc = t.pc; in_inst = {mk(t.pc + 32'd4), mk(t.pc)};
    @(posedge clk);
    #1 idle();
    #1;
    chk({tag, ".valid"}, 64'(out_valid), 64'(t.ev));
    chk({tag, ".pc0"},   64'(out_pc[31:0]),  64'(t.ev[0] ? t.p0 : 32'h0));
    chk({tag, ".pc1"},   64'(out_pc[63:32]), 64'(t.ev[1] ? t.p1 : 32'h0));
    chk({tag, ".inst0"}, 64'(out_inst[31:0]),  64'(t.ev[0] ? mk(t.p0) : NOPV));
    chk({tag, ".inst1"}, 64'(out_inst[63:32]), 64'(t.ev[1] ? mk(t.p1) : NOPV));
    chk({tag, ".ready"}, 64'(in_ready), 64'(t.rdy));
  endtask

  task automatic rand_cycle(input int cyc);
    ent_t b[$];
    ent_t vis[$];
    ent_t e;
    logic [1:0] ev;
    logic ready, acc, byp;
    int nin, t, avail;
    @(negedge clk);
    rst_n = ($urandom_range(0, 199) != 0);
    flush = ($urandom_range(0, 29) == 0);
    case ($urandom_range(0, 2))
      0: in_valid = 2'b00;
      1: in_valid = 2'b01;
      default: in_valid = 2'b11;
    endcase
    dec_take = 2'($urandom_range(0, 3));
    in_pc    = $urandom & 32'hFFFF_FFFC;
    in_inst  = {$urandom, $urandom};
    #1;
    ready = (DEPTH - q.size()) >= 2;
    acc   = in_valid[0] && ready && !flush;
    nin   = acc ? (in_valid[1] ? 2 : 1) : 0;
    e.inst = in_inst[31:0];  e.pc = in_pc;          b.push_back(e);
    e.inst = in_inst[63:32]; e.pc = in_pc + 32'd4;  b.push_back(e);
    byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && !flush;
`endif
    vis.delete();
    if (byp) begin
      for (int k = 0; k < nin; k++) vis.push_back(b[k]);
    end else begin
      for (int k = 0; k < q.size() && k < 2; k++) vis.push_back(q[k]);
    end
    ev = {vis.size() >= 2, vis.size() >= 1};
    chk($sformatf("rnd%0d.valid", cyc), 64'(out_valid), 64'(ev));
    chk($sformatf("rnd%0d.ready", cyc), 64'(in_ready), 64'(ready));
    chk($sformatf("rnd%0d.slot0", cyc), {out_inst[31:0], out_pc[31:0]},
        ev[0] ? {vis[0].inst, vis[0].pc} : {NOPV, 32'h0});
    chk($sformatf("rnd%0d.slot1", cyc), {out_inst[63:32], out_pc[63:32]},
        ev[1] ? {vis[1].inst, vis[1].pc} : {NOPV, 32'h0});
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
    end else if (byp) begin
      t = (dec_take > nin) ? nin : int'(dec_take);
      for (int k = t; k < nin; k++) q.push_back(b[k]);
    end else begin
      avail = (q.size() > 2) ? 2 : q.size();
      t = (dec_take > avail) ? avail : int'(dec_take);
      for (int k = 0; k < t; k++) void'(q.pop_front());
      for (int k = 0; k < nin; k++) q.push_back(b[k]);
    end
  endtask

  vec_t tbl[17];
  vec_t wrp[8];

  initial begin
    idle();
    tbl[0]  = V(0, 0, 2'b00, 0, 32'h0,    2'b00, 0,        0,        1);
    tbl[1]  = V(1, 0, 2'b11, 0, 32'h1000, 2'b11, 32'h1000, 32'h1004, 1);
    tbl[2]  = V(1, 0, 2'b11, 0, 32'h1008, 2'b11, 32'h1000, 32'h1004, 1);
    tbl[3]  = V(1, 0, 2'b11, 0, 32'h1010, 2'b11, 32'h1000, 32'h1004, 1);
    tbl[4]  = V(1, 0, 2'b11, 0, 32'h1018, 2'b11, 32'h1000, 32'h1004, 0);
    tbl[5]  = V(1, 0, 2'b11, 0, 32'h2000, 2'b11, 32'h1000, 32'h1004, 0);
    tbl[6]  = V(1, 0, 2'b00, 2, 32'h0,    2'b11, 32'h1008, 32'h100C, 1);
    tbl[7]  = V(1, 0, 2'b00, 2, 32'h0,    2'b11, 32'h1010, 32'h1014, 1);
    tbl[8]  = V(1, 0, 2'b00, 3, 32'h0,    2'b11, 32'h1018, 32'h101C, 1);
    tbl[9]  = V(1, 0, 2'b00, 1, 32'h0,    2'b01, 32'h101C, 0,        1);
    tbl[10] = V(1, 0, 2'b00, 2, 32'h0,    2'b00, 0,        0,        1);
    tbl[11] = V(1, 0, 2'b01, 0, 32'h3000, 2'b01, 32'h3000, 0,        1);
    tbl[12] = V(1, 0, 2'b11, 0, 32'h3010, 2'b11, 32'h3000, 32'h3010, 1);
    tbl[13] = V(1, 0, 2'b11, 0, 32'h3020, 2'b11, 32'h3000, 32'h3010, 1);
    tbl[14] = V(1, 1, 2'b11, 1, 32'h4000, 2'b00, 0,        0,        1);
    tbl[15] = V(1, 0, 2'b01, 0, 32'h5000, 2'b01, 32'h5000, 0,        1);
    tbl[16] = V(0, 0, 2'b11, 1, 32'h6000, 2'b00, 0,        0,        1);

    // Hold count at 6 across two enqueue+dequeue cycles so the tail wraps 7 -> 0.
    wrp[0] = V(1, 0, 2'b11, 0, 32'h100, 2'b11, 32'h100, 32'h104, 1);
    wrp[1] = V(1, 0, 2'b11, 0, 32'h108, 2'b11, 32'h100, 32'h104, 1);
    wrp[2] = V(1, 0, 2'b11, 0, 32'h110, 2'b11, 32'h100, 32'h104, 1);
    wrp[3] = V(1, 0, 2'b11, 2, 32'h118, 2'b11, 32'h108, 32'h10C, 1);
    wrp[4] = V(1, 0, 2'b11, 2, 32'h120, 2'b11, 32'h110, 32'h114, 1);
    wrp[5] = V(1, 0, 2'b00, 2, 32'h0,   2'b11, 32'h118, 32'h11C, 1);
    wrp[6] = V(1, 0, 2'b00, 2, 32'h0,   2'b11, 32'h120, 32'h124, 1);
    wrp[7] = V(1, 0, 2'b00, 2, 32'h0,   2'b00, 0,       0,       1);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 8; i++)  run_vec(wrp[i], $sformatf("wrap%0d", i));

`ifdef INST_QUEUE_BYPASS_EN
    run_vec(tbl[0], "byp_rst");
    @(negedge clk);
    in_valid = 2'b01; dec_take = 2'd1; in_pc = 32'h2000;
    in_inst = {mk(32'h2004), mk(32'h2000)};
    #1;
    chk("byp.valid", 64'(out_valid), 64'(2'b01));
    chk("byp.pc0",   64'(out_pc[31:0]), 64'(32'h2000));
    chk("byp.inst0", 64'(out_inst[31:0]), 64'(mk(32'h2000)));
    @(posedge clk);
    #1 idle();
    #1;
    chk("byp.after_valid", 64'(out_valid), 64'(2'b00));
    chk("byp.after_ready", 64'(in_ready), 64'(1'b1));
`endif

    run_vec(tbl[0], "rnd_rst");
    q.delete();
    for (int c = 0; c < 3000; c++) rand_cycle(c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
